// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one start/strobe signed multiplier among NREQ requesters
module mul_share_arbiter #(
  parameter int NREQ = 3,
  parameter int W = 12,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [2*W-1:0]    rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_clear,
  input  logic              mul_strobe,
  input  logic [2*W-1:0]    mul_result
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] last, gidx, win, idx;
  logic [CW-1:0] wait_cnt;
  logic tmo;
  always_comb begin
    win = last;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NREQ);
      win = req[idx] ? idx : win;
    end
  end
  assign tmo = wait_cnt == CW'(TIMEOUT - 1);
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE) ? ((|req) ? ISSUE : IDLE) :
               (state == ISSUE) ? WAIT :
               (state == WAIT) ? ((mul_strobe || tmo) ? RESP : WAIT) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last <= IW'(NREQ - 1);
      gidx <= '0;
      wait_cnt <= '0;
      gnt <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      busy <= 1'b0;
      mul_start <= 1'b0;
      mul_a <= '0;
      mul_b <= '0;
      mul_clear <= 1'b0;
    end else begin
      state <= state_nx;
      busy <= state_nx != IDLE;
      gnt <= '0;
      mul_start <= 1'b0;
      rsp_valid <= '0;
      mul_clear <= 1'b0;
      if (state == IDLE && |req) begin
        gidx <= win;
        gnt <= NREQ'(1) << win;
        mul_start <= 1'b1;
        mul_a <= op_a[win*W +: W];
        mul_b <= op_b[win*W +: W];
      end
      if (state == ISSUE) wait_cnt <= '0;
      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
        if (mul_strobe || tmo) begin
          rsp_valid <= NREQ'(1) << gidx;
          rsp_data <= mul_strobe ? mul_result : '0;
          rsp_err <= !mul_strobe;
          mul_clear <= !mul_strobe;
        end
      end
      if (state == RESP) last <= gidx;
    end
  end
endmodule

// File: doc/mul_share_arbiter.md
# mul_share_arbiter

Round-robin arbiter and sequencer that shares one sequential (start/strobe) signed multiplier among NREQ requesters in the geofence datapath. Each requester presents an operand pair with a level request. The block grants one requester and launches the multiplier. It waits for the multiplier's strobe, with a watchdog timeout, and then returns the product to the granted requester with a one-cycle response pulse.

## Interface
- NREQ, 3, number of requesters (2..8)
- W, 12, signed operand width
- TIMEOUT, 31, maximum WAIT cycles before abort (≥2)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  NREQ  level request, bit i = requester i
- op_a  in  NREQ*W  multiplicands, requester i at [i*W +: W]
- op_b  in  NREQ*W  multipliers, same packing
- gnt  out  NREQ  one-hot grant pulse (1 cycle)
- rsp_valid  out  NREQ  one-hot response pulse (1 cycle)
- rsp_data  out  2W  signed product, valid with rsp_valid
- rsp_err  out  1  timeout flag, valid with rsp_valid
- busy  out  1  high in every state except IDLE
- mul_start  out  1  one-cycle launch to multiplier
- mul_a, mul_b  out  W each  latched operands, stable from ISSUE through RESP
- mul_clear  out  1  one-cycle multiplier flush after a timeout
- mul_strobe  in  1  multiplier completion
- mul_result  in  2W  multiplier product, valid with mul_strobe

## Operation
- FSM: IDLE → ISSUE → WAIT → RESP → IDLE. All outputs are registered.
- IDLE: if req ≠ 0, select the winner by round-robin starting at (last+1) mod NREQ.
  - Latch the winner's op_a/op_b into mul_a/mul_b and set gidx = winner.
  - Register gnt = onehot(winner) and mul_start = 1.
  - Go to ISSUE. With req = 0, stay in IDLE.
- ISSUE: gnt and mul_start are high for this cycle only. Clear wait_cnt. Go to WAIT.
- WAIT: wait_cnt increments each cycle.
  - mul_strobe = 1: capture mul_result into rsp_data, rsp_err = 0, go to RESP.
  - Else if wait_cnt == TIMEOUT-1: rsp_data = 0, rsp_err = 1, go to RESP.
  - Strobe wins when both conditions hold in the same cycle.
- RESP: rsp_valid = onehot(gidx) for one cycle. Update last = gidx. Go to IDLE.
  - mul_clear is high during RESP only when rsp_err = 1.
- req is sampled only in IDLE.
  - A requester deasserts req after seeing gnt.
  - If req is still high when the FSM returns to IDLE, it is a new request and competes normally.
- op_a/op_b of non-granted requesters are don't-care. Operands are sampled once, in the IDLE cycle that grants.
- mul_strobe in IDLE, ISSUE or RESP is ignored.
- Width: rsp_data = mul_result unmodified (2W, signed). No truncation inside the block.
- Reset:
  - State IDLE, last = NREQ-1 (so requester 0 has first priority).
  - gnt, rsp_valid, rsp_err, mul_start, mul_clear, busy = 0.
  - rsp_data, mul_a, mul_b, wait_cnt = 0.
  - Reset during WAIT abandons the transaction: no rsp_valid and no mul_clear are issued.

## Timing
- IDLE sees req at cycle t. Cycle t+1: gnt, mul_start and busy high (ISSUE).
- WAIT starts at t+2. A strobe sampled at cycle s gives rsp_valid/rsp_data/rsp_err at s+1. IDLE is reached at s+2.
- Minimum transaction period is 4 cycles (strobe at t+2). Back-to-back grants are 4 + (strobe latency − 1) cycles apart.
- Timeout: with no strobe, rsp_valid with rsp_err = 1 appears at t+2+TIMEOUT.
- busy falls in the cycle after RESP.
- Exactly one bit of gnt and of rsp_valid is high at any time; both are zero otherwise.

## Test plan
- Single request, NREQ=3: req=3'b010, op_a[1]=-5, op_b[1]=7, model strobe 3 cycles after start.
  - Expect gnt=3'b010 at t+1, mul_start at t+1.
  - Expect rsp_valid=3'b010 with rsp_data=-35 and rsp_err=0 at t+5.
- Round-robin: req=3'b111 held high continuously.
  - Expect grant order 0,1,2,0 and rsp_data matching each pair (e.g. 1023×-1024 = -1047552).
- Timeout: TIMEOUT=31, strobe never asserted.
  - Expect rsp_err=1, rsp_data=0 and mul_clear high at t+33.
  - Inject a late strobe during the next IDLE: it is ignored.
- Strobe on the final WAIT cycle (wait_cnt=TIMEOUT-1).
  - Expect rsp_err=0 and the product returned.
- Reset mid-WAIT: assert reset for 1 cycle.
  - Expect all outputs 0 next cycle and no rsp_valid.
  - Next req=3'b100 is serviced, confirming the pointer reset order.
- Requester holds req through RESP.
  - Expect a second grant to the same requester only if no other req bit is set. Otherwise the next requester in round-robin order wins.
